// File: rtl/recur_stack_mem.sv
// rtl/recur_stack_mem.sv - recursion-frame store: append/random-update writes, 1-cycle read port, frame status
module recur_stack_mem #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [31:0]       root_data_i,
  input  logic              seq_we_state,
  input  logic              seq_we_InexRecur,
  input  logic [17:0]       seq_w_data_state,
  input  logic [31:0]       seq_w_data_InexRecur,
  input  logic              ran_we_state,
  input  logic [2:0]        ran_w_mask_state,
  input  logic [17:0]       ran_w_data_state,
  input  logic [ADDR_W-1:0] ran_w_addr_state,
  input  logic              ran_we_InexRecur,
  input  logic [31:0]       ran_w_data_InexRecur,
  input  logic [ADDR_W-1:0] ran_w_addr_InexRecur,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              rd_valid_o,
  output logic [17:0]       rd_state_o,
  output logic [31:0]       rd_InexRecur_o,
  output logic [ADDR_W:0]   frame_cnt_o,
  output logic [ADDR_W:0]   active_cnt_o,
  output logic              full_o,
  output logic              all_done_o,
  output logic              overflow_o,
  output logic              seq_err_o,
  output logic              addr_err_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};

  logic [4:0]       pos_mem    [DEPTH];
  logic [11:0]      parent_mem [DEPTH];
  logic [31:0]      ir_mem     [DEPTH];
  logic [DEPTH-1:0] done_vec;

  logic              seq_both, seq_one, app_ok, app_active;
  logic              st_legal, ir_legal, st_ok, ir_ok;
  logic              old_done, set_done, clr_done, rd_legal;
  logic [ADDR_W-1:0] app_slot;
  logic [ADDR_W:0]   fc_next, ac_next;

  always_comb begin
    seq_both   = seq_we_state & seq_we_InexRecur;
    seq_one    = seq_we_state ^ seq_we_InexRecur;
    app_ok     = seq_both & ~full_o;
    app_active = app_ok & ~seq_w_data_state[0];
    app_slot   = frame_cnt_o[ADDR_W-1:0];
    // legality uses the frame count from the start of the cycle, so the append slot is never legal
    st_legal   = {1'b0, ran_w_addr_state} < frame_cnt_o;
    ir_legal   = {1'b0, ran_w_addr_InexRecur} < frame_cnt_o;
    st_ok      = ran_we_state & st_legal;
    ir_ok      = ran_we_InexRecur & ir_legal;
    old_done   = done_vec[ran_w_addr_state];
    set_done   = st_ok & ran_w_mask_state[0] & ~old_done & ran_w_data_state[0];
    clr_done   = st_ok & ran_w_mask_state[0] & old_done & ~ran_w_data_state[0];
    rd_legal   = {1'b0, rd_addr_i} < frame_cnt_o;

    fc_next = app_ok ? frame_cnt_o + 1'b1 : frame_cnt_o;
    ac_next = active_cnt_o;
    if (app_active) ac_next = ac_next + 1'b1;
    if (clr_done)   ac_next = ac_next + 1'b1;
    if (set_done)   ac_next = ac_next - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_o  <= '0;
      active_cnt_o <= '0;
      full_o       <= 1'b0;
      all_done_o   <= 1'b0;
      overflow_o   <= 1'b0;
      seq_err_o    <= 1'b0;
      addr_err_o   <= 1'b0;
      done_vec     <= '0;
    end else if (start_i) begin
      frame_cnt_o  <= ONE_CNT;
      active_cnt_o <= ONE_CNT;
      full_o       <= 1'b0;
      all_done_o   <= 1'b0;
      overflow_o   <= 1'b0;
      seq_err_o    <= 1'b0;
      addr_err_o   <= 1'b0;
      done_vec     <= '0;
    end else begin
      frame_cnt_o  <= fc_next;
      active_cnt_o <= ac_next;
      full_o       <= (fc_next == FULL_CNT);
      all_done_o   <= (fc_next != '0) && (ac_next == '0);
      overflow_o   <= overflow_o | (seq_both & full_o);
      seq_err_o    <= seq_err_o | seq_one;
      addr_err_o   <= addr_err_o | (ran_we_state & ~st_legal) | (ran_we_InexRecur & ~ir_legal);
      if (app_ok)
        done_vec[app_slot] <= seq_w_data_state[0];
      if (st_ok && ran_w_mask_state[0])
        done_vec[ran_w_addr_state] <= ran_w_data_state[0];
    end
  end

  // Frame payload arrays carry no reset; only the counters define which frames exist.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (start_i) begin
        pos_mem[0]    <= '0;
        parent_mem[0] <= '0;
        ir_mem[0]     <= root_data_i;
      end else begin
        if (app_ok) begin
          pos_mem[app_slot]    <= seq_w_data_state[17:13];
          parent_mem[app_slot] <= seq_w_data_state[12:1];
          ir_mem[app_slot]     <= seq_w_data_InexRecur;
        end
        if (st_ok && ran_w_mask_state[2])
          pos_mem[ran_w_addr_state] <= ran_w_data_state[17:13];
        if (st_ok && ran_w_mask_state[1])
          parent_mem[ran_w_addr_state] <= ran_w_data_state[12:1];
        if (ir_ok)
          ir_mem[ran_w_addr_InexRecur] <= ran_w_data_InexRecur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid_o     <= 1'b0;
      rd_state_o     <= '0;
      rd_InexRecur_o <= '0;
    end else begin
      rd_valid_o <= rd_en_i;
      if (rd_en_i) begin
        rd_state_o     <= rd_legal ? {pos_mem[rd_addr_i], parent_mem[rd_addr_i], done_vec[rd_addr_i]} : '0;
        rd_InexRecur_o <= rd_legal ? ir_mem[rd_addr_i] : '0;
      end
    end
  end

endmodule

// File: doc/recur_stack_mem.md
# recur_stack_mem

Recursion-frame store sitting directly downstream of the write-back stage of the backward-search accelerator. Holds one frame per recursive call: an 18-bit state word (execution position, parent address, done flag) and a 32-bit InexRecur word ({i, z, k, l}). Accepts append writes from write-back's sequential port and field-masked updates from its random port. Serves a one-cycle-latency read port to the fetch stage and reports frame-count, active-frame and completion status to the controller.

## Interface
- ADDR_W, 12, address width; DEPTH = 2^ADDR_W frames
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- start_i  in  1  pulse; begins new search with root frame
- root_data_i  in  32  InexRecur word for root frame
- seq_we_state  in  1  append state word
- seq_we_InexRecur  in  1  append InexRecur word
- seq_w_data_state  in  18  appended state {pos[4:0], parent[11:0], done}
- seq_w_data_InexRecur  in  32  appended {i, z, k, l}
- ran_we_state  in  1  random state update
- ran_w_mask_state  in  3  field enables: [2] pos, [1] parent, [0] done
- ran_w_data_state  in  18  update data; only masked fields used
- ran_w_addr_state  in  ADDR_W  update address
- ran_we_InexRecur  in  1  random InexRecur update, full word
- ran_w_data_InexRecur  in  32  update data
- ran_w_addr_InexRecur  in  ADDR_W  update address
- rd_en_i  in  1  read request
- rd_addr_i  in  ADDR_W  read address
- rd_valid_o  out  1  read data valid
- rd_state_o  out  18  state word read
- rd_InexRecur_o  out  32  InexRecur word read
- frame_cnt_o  out  ADDR_W+1  frames allocated (next append slot)
- active_cnt_o  out  ADDR_W+1  allocated frames with done=0
- full_o  out  1  frame_cnt_o == DEPTH
- all_done_o  out  1  frame_cnt_o != 0 and active_cnt_o == 0
- overflow_o  out  1  sticky: append dropped while full
- seq_err_o  out  1  sticky: only one of the two seq enables asserted
- addr_err_o  out  1  sticky: random write to address >= frame_cnt_o

## Operation
- Storage: separate arrays pos[5], parent[12], InexRecur[32]; done held in flop vector (reset to 0) so done transitions are visible without a read.
- start_i: frame 0 <= {pos 0, parent 0, done 0, root_data_i}; frame_cnt=1, active_cnt=1; clears overflow/seq_err/addr_err. start_i overrides all other writes that cycle.
- Append: accepted only when both seq enables are high and !full_o; writes slot frame_cnt, frame_cnt+1, active_cnt+1 if data bit0 == 0. One enable alone: no write, seq_err_o set. Both high while full: dropped, overflow_o set.
- Random state update: legal if addr < frame_cnt (value at start of cycle); writes only masked fields. Mask bit0 with done 0->1: active_cnt−1; 1->0: +1; no change otherwise. Illegal address: ignored, addr_err_o set.
- Random InexRecur update: same legality rule, full word.
- Same cycle append + random updates: all applied (append slot is never a legal random address); active_cnt changes net (e.g. +1 and −1 → unchanged).
- State and InexRecur random writes to the same frame in one cycle: both applied.
- Read: rd_addr_i sampled when rd_en_i high; data of that frame before this cycle's writes (read-before-write). Address >= frame_cnt returns zeros and rd_valid_o still asserts.

## Timing
- All outputs registered. Reset: rd_valid_o=0, rd_state_o=0, rd_InexRecur_o=0, frame_cnt_o=0, active_cnt_o=0, full_o=0, all_done_o=0, overflow_o=0, seq_err_o=0, addr_err_o=0, done vector all 0; array contents undefined.
- Reset mid-search discards all frames; reset takes priority over start_i.
- Writes take effect at the clock edge; counters and flags reflect them in the same edge (visible next cycle).
- Read latency 1: rd_valid_o high exactly the cycle after rd_en_i; back-to-back reads every cycle supported.
- all_done_o and full_o derived from the registered counters, updated the same edge as the counters.

## Test plan
- Reset then start_i with root_data_i=0x0A0B0C0D; read addr 0 → next cycle rd_valid_o=1, rd_state_o=0, rd_InexRecur_o=0x0A0B0C0D; frame_cnt_o=1, active_cnt_o=1, all_done_o=0.
- Append {pos 0, parent 0, done 0}/0x11223344 → frame_cnt_o=2, active_cnt_o=2; read addr 1 returns 0x11223344.
- Random write addr 1, mask 3'b100, pos=5 → read shows pos 5, parent/done unchanged; mask 3'b001 done=1 → active_cnt_o=1; same to addr 0 → active_cnt_o=0, all_done_o=1.
- Same cycle: append (done 0) plus done-set on addr 0 → active_cnt_o unchanged, frame_cnt_o+1; read same cycle as write to addr 0 returns old data.
- ADDR_W=2: five appends after start → fourth and fifth appends dropped (frame_cnt_o=4, full_o=1, overflow_o=1); random write addr 3 accepted; after start with frame_cnt 1, write addr 2 → addr_err_o=1, no change.
- seq_we_state alone → seq_err_o=1, frame_cnt_o unchanged; rst_n low mid-search → all outputs zero next cycle.
